// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: one shared edge/centre-aligned period counter, per-channel
// shadow duty adjusted by synchronised inc/dec pins and loaded into the active duty at each period start.
module pwm_multichannel #(
    parameter int CHANNELS = 4,
    parameter int PERIOD   = 10,
    parameter int STEP     = 1,
    parameter int DUTY_RST = 5,
    parameter int CNT_W    = $clog2(PERIOD + 1),
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      inc,
    input  logic                      dec,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [CHANNELS*CNT_W-1:0] duty_o
);
    localparam logic [CNT_W-1:0] LP_TOP  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_RST  = CNT_W'(DUTY_RST);
    localparam logic [CNT_W:0]   LP_STEP = (CNT_W + 1)'(STEP);
    localparam logic [SEL_W:0]   LP_NCH  = (SEL_W + 1)'(CHANNELS);

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] sum;
        sum = {1'b0, d} + LP_STEP;
        return (sum > {1'b0, LP_MAX}) ? LP_MAX : sum[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_dec(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] diff;
        diff = {1'b0, d} - LP_STEP;
        return ({1'b0, d} < LP_STEP) ? '0 : diff[CNT_W-1:0];
    endfunction

    logic r_inc_s1, r_inc_s2, r_inc_prev;
    logic r_dec_s1, r_dec_s2, r_dec_prev;
    logic w_inc_evt, w_dec_evt, w_sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inc_s1   <= 1'b0;
            r_inc_s2   <= 1'b0;
            r_inc_prev <= 1'b0;
            r_dec_s1   <= 1'b0;
            r_dec_s2   <= 1'b0;
            r_dec_prev <= 1'b0;
        end else begin
            r_inc_s1   <= inc;
            r_inc_s2   <= r_inc_s1;
            r_inc_prev <= r_inc_s2;
            r_dec_s1   <= dec;
            r_dec_s2   <= r_dec_s1;
            r_dec_prev <= r_dec_s2;
        end
    end

    assign w_inc_evt = r_inc_s2 & ~r_inc_prev;
    assign w_dec_evt = r_dec_s2 & ~r_dec_prev;
    assign w_sel_ok  = ({1'b0, sel} < LP_NCH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_down;
    logic             r_mode_act;
    logic             w_boundary;

    assign w_boundary   = en && (r_cnt == '0) && !r_down;
    // Gated by rst_n so the combinational strobe stays low while reset is held.
    assign period_start = w_boundary && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_down     <= 1'b0;
            r_mode_act <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_down <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_mode_act <= mode;
            end
            // Centre mode repeats each extreme once by flipping direction without stepping.
            if (r_down) begin
                if (r_cnt == '0) begin
                    r_down <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end else if (r_cnt == LP_TOP) begin
                if (r_mode_act) begin
                    r_down <= 1'b1;
                end else begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] r_shadow;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] w_act_nxt;
        logic             w_hit;
        logic             r_pwm;

        assign w_hit     = w_sel_ok && ({1'b0, sel} == (SEL_W + 1)'(g));
        // Compare against the duty that becomes active this cycle so a new period starts cleanly.
        assign w_act_nxt = (w_boundary || !en) ? r_shadow : r_active;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= LP_RST;
                r_active <= LP_RST;
                r_pwm    <= 1'b0;
            end else begin
                r_active <= w_act_nxt;
                r_pwm    <= en && (r_cnt < w_act_nxt);
                if (w_hit && w_inc_evt && !w_dec_evt) begin
                    r_shadow <= f_sat_inc(r_shadow);
                end else if (w_hit && w_dec_evt && !w_inc_evt) begin
                    r_shadow <= f_sat_dec(r_shadow);
                end
            end
        end

        assign pwm_out[g]                 = r_pwm;
        assign duty_o[g*CNT_W +: CNT_W]   = r_shadow;
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: scenario tasks plus random traffic checked cycle by cycle
// against a period-position model of the PWM waveform and duty registers.
module tb_pwm_multichannel;
    localparam int NCH = 4;
    localparam int PER = 10;
    localparam int STP = 1;
    localparam int CW  = 4;

    logic            clk, rst_n, en, mode, inc, dec;
    logic [1:0]      sel;
    logic [NCH-1:0]  pwm_out;
    logic            period_start;
    logic [NCH*CW-1:0] duty_o;
    logic [2:0]      sel2;
    logic [4:0]      pwm5;
    logic            ps5;
    logic [19:0]     duty5;

    int n_vec = 0;
    int n_err = 0;

    pwm_multichannel u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .inc(inc), .dec(dec),
        .pwm_out(pwm_out), .period_start(period_start), .duty_o(duty_o)
    );

    pwm_multichannel #(.CHANNELS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel2), .inc(inc), .dec(dec),
        .pwm_out(pwm5), .period_start(ps5), .duty_o(duty5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Model: position within the current period, shadow/active duties, pending pin events.
    int m_shadow[NCH];
    int m_active[NCH];
    bit m_pwm[NCH];
    bit m_mode_act;
    int m_p;
    int edge_n;
    bit pend_inc[4];
    bit pend_dec[4];
    bit last_inc, last_dec;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = 5;
            m_active[i] = 5;
            m_pwm[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            pend_inc[i] = 1'b0;
            pend_dec[i] = 1'b0;
        end
        m_mode_act = 1'b0;
        m_p = 0;
        edge_n = 0;
        last_inc = 1'b0;
        last_dec = 1'b0;
    endfunction

    function automatic void model_edge();
        int slot, c, len, s;
        bit di, dd;
        edge_n++;
        slot = edge_n % 4;
        di = pend_inc[slot];
        dd = pend_dec[slot];
        pend_inc[slot] = 1'b0;
        pend_dec[slot] = 1'b0;
        // A pin rise seen at this edge reaches the shadow two edges later.
        if (inc && !last_inc) pend_inc[(edge_n + 2) % 4] = 1'b1;
        if (dec && !last_dec) pend_dec[(edge_n + 2) % 4] = 1'b1;
        last_inc = inc;
        last_dec = dec;
        if (!en) begin
            m_p = 0;
            for (int i = 0; i < NCH; i++) begin
                m_active[i] = m_shadow[i];
                m_pwm[i] = 1'b0;
            end
        end else begin
            if (m_p == 0) begin
                for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
                m_mode_act = mode;
            end
            len = m_mode_act ? 2 * PER : PER;
            c = (m_p < PER) ? m_p : (2 * PER - 1 - m_p);
            for (int i = 0; i < NCH; i++) m_pwm[i] = (c < m_active[i]);
            m_p = (m_p + 1) % len;
        end
        s = int'(sel);
        if (di != dd && s < NCH) begin
            if (di) m_shadow[s] = (m_shadow[s] + STP > PER) ? PER : m_shadow[s] + STP;
            else    m_shadow[s] = (m_shadow[s] - STP < 0) ? 0 : m_shadow[s] - STP;
        end
    endfunction

    function automatic logic [NCH-1:0] m_pwm_v();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pwm[i];
        return v;
    endfunction

    function automatic logic [NCH*CW-1:0] m_duty_v();
        logic [NCH*CW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(m_shadow[i]);
        return v;
    endfunction

    function automatic logic m_ps();
        return rst_n && en && (m_p == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        while (period_start !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_vec++;
        if (period_start !== 1'b1) begin
            n_err++;
            $display("FAIL wait_ps timeout period_start=%b required 1", period_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; inc = 1'b0; dec = 1'b0; sel2 = 3'd5;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (pwm_out !== 4'b0000 || pwm5 !== 5'b0) begin
            n_err++; $display("FAIL reset_pwm pwm=%b pwm5=%b required 0", pwm_out, pwm5);
        end
        n_vec++;
        if (period_start !== 1'b0 || ps5 !== 1'b0) begin
            n_err++; $display("FAIL reset_ps ps=%b ps5=%b required 0", period_start, ps5);
        end
        n_vec++;
        if (duty_o !== 16'h5555) begin
            n_err++; $display("FAIL reset_duty duty=%h required 5555", duty_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int hi[NCH];
        int ps_cnt;
        ps_cnt = 0;
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        en = 1'b1;
        #1;
        n_vec++;
        if (period_start !== 1'b1) begin
            n_err++; $display("FAIL en_rise_ps ps=%b required 1", period_start);
        end
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL defaults t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
            ps_cnt += int'(period_start);
        end
        for (int i = 0; i < NCH; i++) begin
            n_vec++;
            if (hi[i] != 20) begin
                n_err++; $display("FAIL defaults_high ch%0d high=%0d required 20", i, hi[i]);
            end
        end
        n_vec++;
        if (ps_cnt != 4) begin
            n_err++; $display("FAIL defaults_ps count=%0d required 4", ps_cnt);
        end
    endtask

    task automatic test_inc_sel2();
        int h2[3];
        int h0[3];
        for (int b = 0; b < 3; b++) begin h2[b] = 0; h0[b] = 0; end
        wait_ps();
        for (int t = 1; t <= 30; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL inc_sel2 t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            h2[(t - 1) / 10] += int'(pwm_out[2]);
            h0[(t - 1) / 10] += int'(pwm_out[0]);
            sel = 2'd2;
            inc = (t == 2 || t == 4 || t == 6);
        end
        n_vec++;
        if (h2[0] != 5 || h2[1] != 8 || h2[2] != 8) begin
            n_err++; $display("FAIL inc_sel2_high ch2=%0d,%0d,%0d required 5,8,8", h2[0], h2[1], h2[2]);
        end
        n_vec++;
        if (h0[1] != 5) begin
            n_err++; $display("FAIL inc_sel2_ch0 high=%0d required 5", h0[1]);
        end
        n_vec++;
        if (duty_o !== 16'h5855) begin
            n_err++; $display("FAIL inc_sel2_duty duty=%h required 5855", duty_o);
        end
    endtask

    task automatic test_saturate();
        int h;
        sel = 2'd0;
        for (int ph = 0; ph < 2; ph++) begin
            h = 0;
            for (int t = 1; t <= 64; t++) begin
                tick();
                n_vec++;
                if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                    n_err++;
                    $display("FAIL saturate ph=%0d t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                             ph, t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
                end
                if (t > 44) h += int'(pwm_out[0]);
                if (ph == 0) dec = (t <= 24) && (t % 2 == 1);
                else         inc = (t <= 24) && (t % 2 == 1);
            end
            n_vec++;
            if (h != (ph == 0 ? 0 : 20)) begin
                n_err++; $display("FAIL saturate_high ph=%0d high=%0d required %0d", ph, h, ph == 0 ? 0 : 20);
            end
            n_vec++;
            if (duty_o[3:0] !== (ph == 0 ? 4'd0 : 4'd10)) begin
                n_err++; $display("FAIL saturate_duty ph=%0d duty0=%0d required %0d", ph, duty_o[3:0], ph == 0 ? 0 : 10);
            end
        end
    endtask

    task automatic test_corner();
        sel = 2'd1;
        inc = 1'b1;
        dec = 1'b1;
        for (int t = 1; t <= 62; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL corner t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            if (t == 3) begin inc = 1'b0; dec = 1'b0; end
            if (t == 6) begin
                n_vec++;
                if (duty_o[7:4] !== 4'd5) begin
                    n_err++; $display("FAIL both_edges duty1=%0d required 5", duty_o[7:4]);
                end
                inc = 1'b1;
            end
            if (t == 56) inc = 1'b0;
        end
        n_vec++;
        if (duty_o[7:4] !== 4'd6) begin
            n_err++; $display("FAIL held_inc duty1=%0d required 6", duty_o[7:4]);
        end
        n_vec++;
        if (duty5 !== 20'h55555) begin
            n_err++; $display("FAIL sel_out_of_range duty5=%h required 55555", duty5);
        end
        sel2 = 3'd4;
        inc = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 2) inc = 1'b0;
        end
        n_vec++;
        if (duty5 !== 20'h65555) begin
            n_err++; $display("FAIL sel_in_range duty5=%h required 65555", duty5);
        end
        sel2 = 3'd6;
    endtask

    task automatic test_centre();
        int psq[$];
        logic [19:0] pat;
        pat = '0;
        wait_ps();
        for (int t = 1; t <= 60; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL centre t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            if (period_start === 1'b1) psq.push_back(t);
            if (t >= 11 && t <= 30) pat[t - 11] = pwm_out[3];
            if (t == 3) mode = 1'b1;
        end
        n_vec++;
        if (psq.size() != 3 || psq[0] != 10 || psq[1] != 30 || psq[2] != 50) begin
            n_err++; $display("FAIL centre_ps n=%0d first=%0d required 3 strobes at 10,30,50",
                              psq.size(), psq.size() > 0 ? psq[0] : -1);
        end
        n_vec++;
        if (pat !== 20'hF801F) begin
            n_err++; $display("FAIL centre_shape ch3=%b required %b", pat, 20'hF801F);
        end
    endtask

    task automatic test_enable();
        mode = 1'b0;
        for (int t = 1; t <= 5; t++) tick();
        en = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== 4'b0 || period_start !== 1'b0 || duty_o !== m_duty_v()) begin
                n_err++; $display("FAIL en_low t=%0d pwm=%b ps=%b required 0,0", t, pwm_out, period_start);
            end
        end
        en = 1'b1;
        #1;
        n_vec++;
        if (period_start !== 1'b1) begin
            n_err++; $display("FAIL en_rise_ps2 ps=%b required 1", period_start);
        end
        for (int t = 1; t <= 30; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL enable t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            if (t == 1) begin
                n_vec++;
                if (pwm_out[3] !== 1'b1) begin
                    n_err++; $display("FAIL en_first_high ch3=%b required 1", pwm_out[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 1; t <= 400; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL random t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            en   = ($urandom_range(0, 15) != 0);
            mode = ($urandom_range(0, 31) == 0) ? ~mode : mode;
            sel  = 2'($urandom);
            inc  = ($urandom_range(0, 2) == 0);
            dec  = ($urandom_range(0, 3) == 0);
        end
        en = 1'b1;
        inc = 1'b0;
        dec = 1'b0;
    endtask

    task automatic test_reset_mid();
        int h;
        h = 0;
        n_vec++;
        if (duty5 !== 20'h65555) begin
            n_err++; $display("FAIL sel_out_of_range2 duty5=%h required 65555", duty5);
        end
        mode = 1'b0;
        for (int t = 1; t <= 13; t++) tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (pwm_out !== 4'b0 || duty_o !== 16'h5555 || duty5 !== 20'h55555) begin
            n_err++; $display("FAIL reset_mid pwm=%b duty=%h duty5=%h required 0,5555,55555", pwm_out, duty_o, duty5);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            n_vec++;
            if (pwm_out !== m_pwm_v() || period_start !== m_ps() || duty_o !== m_duty_v()) begin
                n_err++;
                $display("FAIL after_reset t=%0d pwm=%b exp %b ps=%b exp %b duty=%h exp %h",
                         t, pwm_out, m_pwm_v(), period_start, m_ps(), duty_o, m_duty_v());
            end
            if (t <= 20) h += int'(pwm_out[1]);
        end
        n_vec++;
        if (h != 10) begin
            n_err++; $display("FAIL after_reset_high ch1=%0d required 10", h);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_inc_sel2();
        test_saturate();
        test_corner();
        test_centre();
        test_enable();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
